// File: rtl/md_ram_pp_ctrl.sv
// md_ram_pp_ctrl: ping-pong controller for two md_ram banks (16x32 two-port
// register files). The producer fills one bank while the consumer drains the
// other as a fixed-length burst.
//
// Optional feature: define MD_RAM_PP_CTRL_ERR_EN to enable sticky protocol
// error flags on err_o; otherwise err_o is tied to 2'b00.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wr_val_i, wr_data_i     producer word stream
//   wr_rdy_o                controller accepts a word this cycle
//   rd_avail_o              full bank waiting and no burst active
//   rd_start_i              consumer starts a block burst
//   rd_val_o, rd_data_o     burst word (registered valid)
//   rd_last_o               final word of the block
//   ramN_we/waddr/wdata_o   bank N write port controls (N=0,1)
//   ramN_rd/raddr_o         bank N read port controls
//   ramN_rdata_i            bank N read data (1-cycle latency)
//   err_o                   sticky errors: [0] overflow, [1] bad start
module md_ram_pp_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_val_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_rdy_o,
  output logic                  rd_avail_o,
  input  logic                  rd_start_i,
  output logic                  rd_val_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  ram0_we_o,
  output logic [ADDR_WIDTH-1:0] ram0_waddr_o,
  output logic [DATA_WIDTH-1:0] ram0_wdata_o,
  output logic                  ram0_rd_o,
  output logic [ADDR_WIDTH-1:0] ram0_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram0_rdata_i,
  output logic                  ram1_we_o,
  output logic [ADDR_WIDTH-1:0] ram1_waddr_o,
  output logic [DATA_WIDTH-1:0] ram1_wdata_o,
  output logic                  ram1_rd_o,
  output logic [ADDR_WIDTH-1:0] ram1_raddr_o,
  input  logic [DATA_WIDTH-1:0] ram1_rdata_i,
  output logic [1:0]            err_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_st_e;

  bank_st_e              bank0_q, bank1_q;
  rd_st_e                rd_st_q;
  logic                  wr_bank_q, rd_bank_q;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  rd_val_q, rd_last_q, rd_sel_q;

  bank_st_e wr_bank_st, rd_bank_st;
  logic     wr_fire, rd_fire, rd_issue;

  // Status of the bank currently addressed by each side
  assign wr_bank_st = wr_bank_q ? bank1_q : bank0_q;
  assign rd_bank_st = rd_bank_q ? bank1_q : bank0_q;

  assign wr_rdy_o   = (wr_bank_st == B_EMPTY) || (wr_bank_st == B_FILLING);
  assign rd_avail_o = (rd_st_q == RD_IDLE) && (rd_bank_st == B_FULL);

  assign wr_fire  = wr_val_i & wr_rdy_o;
  assign rd_fire  = rd_start_i & rd_avail_o;
  assign rd_issue = (rd_st_q == RD_BURST);

  assign wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
  assign rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);

  // RAM write port: the bank captures the word on the same edge
  assign ram0_we_o    = wr_fire & ~wr_bank_q;
  assign ram1_we_o    = wr_fire &  wr_bank_q;
  assign ram0_waddr_o = wr_cnt_q;
  assign ram1_waddr_o = wr_cnt_q;
  assign ram0_wdata_o = wr_data_i;
  assign ram1_wdata_o = wr_data_i;

  // RAM read port: one read per burst cycle, no stalls
  assign ram0_rd_o    = rd_issue & ~rd_bank_q;
  assign ram1_rd_o    = rd_issue &  rd_bank_q;
  assign ram0_raddr_o = rd_cnt_q;
  assign ram1_raddr_o = rd_cnt_q;

  // Read data arrives one cycle after issue; the registered select follows it
  assign rd_val_o  = rd_val_q;
  assign rd_last_o = rd_last_q;
  assign rd_data_o = rd_val_q ? (rd_sel_q ? ram1_rdata_i : ram0_rdata_i)
                              : '0;

  // Bank status, write pointer and read FSM. The write and read sides never
  // address the same bank in one cycle, so their status updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q   <= B_EMPTY;
      bank1_q   <= B_EMPTY;
      rd_st_q   <= RD_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_val_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_sel_q  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt_q <= wr_cnt_d;
        if (wr_cnt_q == LAST_ADDR) begin
          if (wr_bank_q) bank1_q <= B_FULL;
          else           bank0_q <= B_FULL;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          if (wr_bank_q) bank1_q <= B_FILLING;
          else           bank0_q <= B_FILLING;
        end
      end

      case (rd_st_q)
        RD_IDLE: begin
          if (rd_fire) begin
            rd_st_q  <= RD_BURST;
            rd_cnt_q <= '0;
            if (rd_bank_q) bank1_q <= B_DRAINING;
            else           bank0_q <= B_DRAINING;
          end
        end
        RD_BURST: begin
          rd_cnt_q <= rd_cnt_d;
          if (rd_cnt_q == LAST_ADDR) begin
            rd_st_q   <= RD_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= ~rd_bank_q;
            if (rd_bank_q) bank1_q <= B_EMPTY;
            else           bank0_q <= B_EMPTY;
          end
        end
        default: rd_st_q <= RD_IDLE;
      endcase

      rd_val_q  <= rd_issue;
      rd_last_q <= rd_issue && (rd_cnt_q == LAST_ADDR);
      if (rd_issue) rd_sel_q <= rd_bank_q;
    end
  end

`ifdef MD_RAM_PP_CTRL_ERR_EN
  logic [1:0] err_q;

  // Sticky flags: [0] write while not ready, [1] start while nothing available
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_q | {rd_start_i & ~rd_avail_o, wr_val_i & ~wr_rdy_o};
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_md_ram_pp_ctrl.sv
// Bench for md_ram_pp_ctrl: behavioural RAM banks, a block-level reference
// model (FIFO of accepted words, count of full blocks) and a cycle-stamped
// scoreboard consumed by a separate output monitor.
module tb_md_ram_pp_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_val_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_rdy_o, rd_avail_o;
  logic          rd_start_i = 1'b0;
  logic          rd_val_o, rd_last_o;
  logic [DW-1:0] rd_data_o;
  logic          ram0_we_o, ram1_we_o, ram0_rd_o, ram1_rd_o;
  logic [AW-1:0] ram0_waddr_o, ram1_waddr_o, ram0_raddr_o, ram1_raddr_o;
  logic [DW-1:0] ram0_wdata_o, ram1_wdata_o;
  logic [DW-1:0] ram0_rdata_i = '0;
  logic [DW-1:0] ram1_rdata_i = '0;
  logic [1:0]    err_o;

  md_ram_pp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_val_i(wr_val_i), .wr_data_i(wr_data_i), .wr_rdy_o(wr_rdy_o),
    .rd_avail_o(rd_avail_o), .rd_start_i(rd_start_i),
    .rd_val_o(rd_val_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .ram0_we_o(ram0_we_o), .ram0_waddr_o(ram0_waddr_o), .ram0_wdata_o(ram0_wdata_o),
    .ram0_rd_o(ram0_rd_o), .ram0_raddr_o(ram0_raddr_o), .ram0_rdata_i(ram0_rdata_i),
    .ram1_we_o(ram1_we_o), .ram1_waddr_o(ram1_waddr_o), .ram1_wdata_o(ram1_wdata_o),
    .ram1_rd_o(ram1_rd_o), .ram1_raddr_o(ram1_raddr_o), .ram1_rdata_i(ram1_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-port register files with registered read data
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (ram0_we_o) mem0[ram0_waddr_o] <= ram0_wdata_o;
    if (ram1_we_o) mem1[ram1_waddr_o] <= ram1_wdata_o;
    if (ram0_rd_o) ram0_rdata_i <= mem0[ram0_raddr_o];
    if (ram1_rd_o) ram1_rdata_i <= mem1[ram1_raddr_o];
  end

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    int unsigned   at;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] pend[$];
  int unsigned   wr_total = 0;
  int unsigned   blocks_read = 0;
  int            n_full = 0;
  bit            burst = 1'b0;
  int unsigned   rd_pos = 0;
  logic [1:0]    err_e = 2'b00;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    pend.delete();
    wr_total    = 0;
    blocks_read = 0;
    n_full      = 0;
    burst       = 1'b0;
    rd_pos      = 0;
    err_e       = 2'b00;
  endtask

  // One clock cycle: drive, check the cycle's controls against the model,
  // then advance the model to the next edge.
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rs);
    bit wr_rdy_e, avail_e, fire_w, fire_s, wb, rb;
    @(negedge clk);
    wr_val_i   = wv;
    wr_data_i  = wd;
    rd_start_i = rs;
    #1;
    wr_rdy_e = (n_full + (burst ? 1 : 0)) < 2;
    avail_e  = !burst && (n_full > 0);
    fire_w   = wv && wr_rdy_e;
    fire_s   = rs && avail_e;
    wb       = ((wr_total / DEPTH) % 2) == 1;
    rb       = (blocks_read % 2) == 1;

    chk("wr_rdy", 32'(wr_rdy_o), 32'(wr_rdy_e));
    chk("rd_avail", 32'(rd_avail_o), 32'(avail_e));
    chk("ram0_we", 32'(ram0_we_o), 32'(fire_w && !wb));
    chk("ram1_we", 32'(ram1_we_o), 32'(fire_w && wb));
    if (fire_w) begin
      chk("waddr", 32'(wb ? ram1_waddr_o : ram0_waddr_o), 32'(wr_total % DEPTH));
      chk("wdata", wb ? ram1_wdata_o : ram0_wdata_o, wd);
    end
    chk("ram0_rd", 32'(ram0_rd_o), 32'(burst && !rb));
    chk("ram1_rd", 32'(ram1_rd_o), 32'(burst && rb));
    if (burst) chk("raddr", 32'(rb ? ram1_raddr_o : ram0_raddr_o), 32'(rd_pos));
    chk("err", 32'(err_o), 32'(err_e));

`ifdef MD_RAM_PP_CTRL_ERR_EN
    err_e = err_e | {rs && !avail_e, wv && !wr_rdy_e};
`endif
    if (burst) begin
      if (rd_pos == DEPTH - 1) begin
        burst = 1'b0;
        blocks_read++;
      end
      rd_pos++;
    end
    if (fire_s) begin
      burst  = 1'b1;
      rd_pos = 0;
      n_full--;
      for (int k = 0; k < int'(DEPTH); k++) begin
        exp_t e;
        e.data = pend.pop_front();
        e.last = (k == int'(DEPTH) - 1);
        e.at   = cyc + 2 + k;
        sbq.push_back(e);
      end
    end
    if (fire_w) begin
      pend.push_back(wd);
      wr_total++;
      if ((wr_total % DEPTH) == 0) n_full++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_val_i   = 1'b0;
    rd_start_i = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_wr_rdy", 32'(wr_rdy_o), 32'd1);
    chk("rst_rd_avail", 32'(rd_avail_o), 32'd0);
    chk("rst_rd_val", 32'(rd_val_o), 32'd0);
    chk("rst_rd_last", 32'(rd_last_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("rst_enables", 32'({ram0_we_o, ram1_we_o, ram0_rd_o, ram1_rd_o}), 32'd0);
    chk("rst_addrs", 32'({ram0_waddr_o, ram1_waddr_o, ram0_raddr_o, ram1_raddr_o}), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Output monitor: every rd_val_o must match the scoreboard head, on time
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_val_o) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_val_unexpected: got data %0h expected no output (cycle %0d)",
                   rd_data_o, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rd_data", rd_data_o, e.data);
          chk("rd_last", 32'(rd_last_o), 32'(e.last));
          chk("rd_cycle", cyc, e.at);
        end
      end else if (sbq.size() > 0 && sbq[0].at <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL rd_val_missing: got no output expected data %0h at cycle %0d",
                 e.data, e.at);
      end
    end
  end

  initial begin
    do_reset();

    // Premature start with both banks empty
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Single block 0x100..0x10F, then one start pulse
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);

    // Overlap: block A, then stream B while A drains
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'hA00 + 32'(i), 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'hB00 + 32'(i), i == 0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);

    // Backpressure: fill both banks, then one extra word
    for (int i = 0; i < 2 * int'(DEPTH); i++) step(1'b1, $urandom(), 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, '0, 1'b0);

    // Back-to-back bursts with rd_start_i held high
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 5) == 0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);

    // Reset in the middle of a burst, then a clean block afterwards
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'hC00 + 32'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 32'hD00 + 32'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b0, '0, 1'b0);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_ram_pp_ctrl.md
Name: md_ram_pp_ctrl

Overview:
Ping-pong controller for two md_ram banks (16x32 two-port register files) in the pre-intra mode-decision path.
- Accepts a sequential stream of 8x8 cost/mode words from the producer and fills one bank.
- Hands a full bank to the consumer, which drains it as an automatic burst.
- Drives the RAM-side write and read controls for both banks. Producer and consumer therefore overlap on alternate 8x8 blocks.

Parameters:
ADDR_WIDTH, 4, word address width per bank; DEPTH = 2^ADDR_WIDTH words per block
DATA_WIDTH, 32, word width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_val_i  input  1  producer word valid
wr_data_i  input  DATA_WIDTH  producer word
wr_rdy_o  output  1  controller can accept a word this cycle
rd_avail_o  output  1  a full bank is waiting and no burst is active
rd_start_i  input  1  consumer starts a block burst
rd_val_o  output  1  rd_data_o valid
rd_data_o  output  DATA_WIDTH  burst word
rd_last_o  output  1  with rd_val_o, marks the final word of the block
ramN_we_o  output  1  bank N write enable (N=0,1)
ramN_waddr_o  output  ADDR_WIDTH  bank N write address
ramN_wdata_o  output  DATA_WIDTH  bank N write data
ramN_rd_o  output  1  bank N read enable
ramN_raddr_o  output  ADDR_WIDTH  bank N read address
ramN_rdata_i  input  DATA_WIDTH  bank N read data (registered, 1-cycle latency)
err_o  output  2  sticky protocol errors (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - Both banks EMPTY; wr_bank=0, rd_bank=0; wr_cnt=0, rd_cnt=0; read FSM IDLE.
  - Outputs: wr_rdy_o=1, rd_avail_o=0, rd_val_o=0, rd_last_o=0, rd_data_o=0, all ram*_we_o/rd_o=0, addresses=0, err_o=0.
  - Reset mid-burst abandons all contents.
- Bank status, per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - wr_rdy_o=1 iff bank[wr_bank] is EMPTY or FILLING.
  - On wr_val_i & wr_rdy_o: combinationally assert ram[wr_bank]_we_o=1, waddr=wr_cnt, wdata=wr_data_i (the RAM captures it at the same edge).
  - Same edge: wr_cnt increments (wraps DEPTH-1 -> 0).
  - At wr_cnt=DEPTH-1: bank becomes FULL and wr_bank toggles.
  - wr_val_i with wr_rdy_o=0 is dropped; no RAM write.
- Read FSM, states IDLE, BURST:
  - rd_avail_o=1 iff FSM=IDLE and bank[rd_bank] is FULL.
  - IDLE -> BURST on rd_start_i & rd_avail_o; bank becomes DRAINING.
  - In BURST: ram[rd_bank]_rd_o=1 and raddr=rd_cnt each cycle; rd_cnt increments, 16 consecutive cycles with no stall.
  - After the cycle with rd_cnt=DEPTH-1: FSM returns to IDLE, bank becomes EMPTY, rd_bank toggles, rd_cnt=0.
- Read data path:
  - rd_val_o is registered: high exactly 1 cycle after each read issue.
  - rd_data_o = ramN_rdata_i of the bank that was read, muxed by a registered bank select.
  - rd_last_o accompanies word DEPTH-1.
  - rd_start_i is latency 2 to the first rd_val_o. Burst length is exactly DEPTH.
- Throughput and concurrency:
  - Back-to-back: if the other bank is FULL when a burst ends, rd_avail_o rises the next cycle. A new burst may start then, so there is 1 idle cycle between bursts.
  - Simultaneous write and read always target different banks by construction; no arbitration needed.
  - A bank freed at the end of a burst is writable from the next cycle.
  - Write to a bank and read of the same bank never occur in the same cycle.
- Both banks FULL: wr_rdy_o=0 until a burst completes.

Optional Feature:
Macro MD_RAM_PP_CTRL_ERR_EN.
- Defined:
  - err_o[0] sets sticky on wr_val_i & ~wr_rdy_o (overflow).
  - err_o[1] sets sticky on rd_start_i & ~rd_avail_o (underflow, or start during a burst).
  - Both bits clear only on reset.
- Not defined: err_o tied to 2'b00. Offending requests are still ignored identically.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-burst.
  - Response: next sample shows wr_rdy_o=1, rd_avail_o=0, rd_val_o=0, and all RAM enables 0.
- Single block:
  - Stimulus: write 16 words 0x100..0x10F back-to-back; 1 cycle after the last write, rd_avail_o=1; pulse rd_start_i.
  - Response: rd_val_o for 16 cycles starting 2 cycles after rd_start_i, data 0x100..0x10F in order, rd_last_o only on 0x10F.
- Overlap:
  - Stimulus: write block A (0xA00..0xA0F), start its burst, and stream block B (0xB00..0xB0F) into bank 1 concurrently.
  - Response: bank 0 reads and bank 1 writes never collide; B then reads out intact.
- Backpressure:
  - Stimulus: fill both banks (32 words) without reading.
  - Response: wr_rdy_o=0; a 33rd wr_val_i causes no ram*_we_o. With ERR_EN, err_o=2'b01.
- Premature start:
  - Stimulus: pulse rd_start_i with both banks EMPTY.
  - Response: no ram*_rd_o and no rd_val_o. With ERR_EN, err_o[1]=1.
- Back-to-back bursts:
  - Stimulus: both banks FULL; hold rd_start_i=1.
  - Response: 32 words output with exactly 1 idle rd_val_o cycle between blocks; wr_rdy_o rises the cycle after the first burst ends.
